rob_alloc: RTL and testbench
============================

// Module: rob_alloc
// PURPOSE
//  In-order ROB slot allocator on the issue side; produces the robIdx that execution ports hand back to rob.
//  Tracks tail pointer and occupancy; stalls issue when all ROB_SLOTS entries are in flight.
//  Frees one slot per cycle when rob retires its head (commit pulse).
//  Re-synchronises with rob's head on clear/flush.
// PARAMETERS
//  ROB_SLOTS     16  number of ROB entries; any value >=2, need not be a power of 2
//  ROB_IDX_BITS  4   width of a ROB index; must satisfy 2**ROB_IDX_BITS >= ROB_SLOTS
//  FLUSH_CYCLES  1   cycles allocation stays blocked after clear; must be >=1
// PORTS
//  clk         in   1               clock
//  rst         in   1               synchronous reset, active-high
//  clear       in   1               pipeline flush; same pulse that clears rob
//  allocReq    in   1               issue stage wants one slot this cycle
//  allocGrant  out  1               slot granted; allocation fires when allocReq && allocGrant
//  allocIdx    out  ROB_IDX_BITS    robIdx assigned to the requesting instruction (= tail)
//  commit      in   1               rob retired its head entry this cycle
//  full        out  1               count == ROB_SLOTS
//  empty       out  1               count == 0
//  freeSlots   out  ROB_IDX_BITS+1  ROB_SLOTS - count
//  err         out  1               sticky: commit received while empty
// BEHAVIOUR
//  - Reset (rst sampled high at posedge): tail=0, count=0, state=FLUSH with counter=FLUSH_CYCLES,
//    err=0, full=0, empty=1, freeSlots=ROB_SLOTS, allocGrant=0. rst has priority over every other input.
//  - FSM: FLUSH -> RUN after FLUSH_CYCLES cycles with clear low; RUN -> FLUSH on clear.
//    clear in FLUSH reloads the counter to FLUSH_CYCLES.
//  - clear (no rst): tail=0, count=0, err unchanged; alloc and commit in that cycle are discarded.
//  - allocGrant = (state==RUN) && !full && !clear; combinational from registered state only.
//  - allocIdx = tail; valid whenever allocGrant=1; undefined content otherwise.
//  - Fire (allocReq && allocGrant): tail <= (tail==ROB_SLOTS-1) ? 0 : tail+1 at the next edge.
//    No combinational path from allocReq to allocGrant.
//  - count_next = count + fire - (commit && count!=0); counter saturates at neither end.
//    Simultaneous fire and commit leaves count unchanged.
//  - Full: no bypass. A commit arriving while full does not allow a grant in the same cycle;
//    the freed slot becomes grantable the next cycle.
//  - commit while count==0: ignored; err <= 1 and stays set until rst.
//  - full/empty/freeSlots are registered-derived (decoded from count), valid one cycle after each update.
//  - Invariant: tail - count (mod ROB_SLOTS) equals rob's head index; no separate head register is kept.
// CONFIGURATION
//  ROB_ALLOC_STATS_EN defined: adds outputs stallCycles[31:0] and allocCount[31:0].
//    stallCycles++ on each cycle with allocReq && !allocGrant; allocCount++ on each fire.
//    Both cleared only by rst (not by clear) and wrap at 2**32.
//  ROB_ALLOC_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package proc: ROB_SLOTS, ROB_IDX_BITS, ARCH_BITS; rob and rob_alloc use the same values.
//  - State encoding (ST_RUN, ST_FLUSH) is local to this module.
//  - One sub-module: rob_ptr_wrap, a modulo-ROB_SLOTS index incrementer; also usable by rob for its head.
//  - Single always block for tail/count/FSM, plus an optional stats block under the macro.
// TESTING
//  - Reset: after rst, FLUSH_CYCLES=1 -> allocGrant=0 for 1 cycle, then 1 with allocIdx=0, freeSlots=16.
//  - Fill: 16 back-to-back fires, no commit -> idx 0..15 issued, full=1, allocGrant=0 on the 17th cycle.
//  - Full plus commit: while full, commit and allocReq in the same cycle -> no grant that cycle;
//    next cycle grant=1, idx=0 (wrapped), count=16.
//  - Steady state: fire and commit every cycle for 40 cycles from count=3 -> count stays 3,
//    idx sequence wraps 15->0.
//  - Flush: count=9, tail=9, assert clear with allocReq high -> no fire;
//    next cycle tail=0, empty=1; grant resumes after FLUSH_CYCLES.
//  - Underflow: commit while empty -> err=1, count stays 0; err persists across clear, clears on rst.

Source files
------------

// File: rtl/rob_alloc_pkg.sv
// -----------------------------------------------------------------------------
// rob_alloc_pkg
// Shared processor-core sizing used by rob and rob_alloc so both agree on the
// number of reorder-buffer entries and the width of a ROB index.
//   DEF_ROB_SLOTS     : number of ROB entries (need not be a power of two)
//   DEF_ROB_IDX_BITS  : width of a ROB index, 2**DEF_ROB_IDX_BITS >= DEF_ROB_SLOTS
//   ARCH_BITS         : width of an architectural register index
//   DEF_FLUSH_CYCLES  : cycles allocation stays blocked after a clear
// -----------------------------------------------------------------------------
package rob_alloc_pkg;

    localparam int DEF_ROB_SLOTS    = 16;
    localparam int DEF_ROB_IDX_BITS = 4;
    localparam int ARCH_BITS        = 5;
    localparam int DEF_FLUSH_CYCLES = 1;

    // Even parity over a ROB index, available for protected index transport.
    function automatic logic idx_parity(input logic [DEF_ROB_IDX_BITS-1:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/rob_alloc_ptr_wrap.sv
// -----------------------------------------------------------------------------
// rob_ptr_wrap
// Modulo-SLOTS index incrementer: o_idx_next = (i_idx == SLOTS-1) ? 0 : i_idx+1.
// Purely combinational; shared by the allocator tail and the rob head.
//   i_idx       in  IDX_BITS   current index (always < SLOTS)
//   o_idx_next  out IDX_BITS   next index, wrapped at SLOTS
// -----------------------------------------------------------------------------
module rob_ptr_wrap #(
    parameter int SLOTS    = 16,
    parameter int IDX_BITS = 4
) (
    input  logic [IDX_BITS-1:0] i_idx,
    output logic [IDX_BITS-1:0] o_idx_next
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(SLOTS - 1);

    // Wrap explicitly instead of relying on binary overflow: SLOTS may not be a power of two.
    always_comb begin
        o_idx_next = i_idx + {{(IDX_BITS-1){1'b0}}, 1'b1};
        if (i_idx == LAST_IDX) begin
            o_idx_next = {IDX_BITS{1'b0}};
        end else begin
            o_idx_next = i_idx + {{(IDX_BITS-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/rob_alloc.sv
// -----------------------------------------------------------------------------
// rob_alloc
// In-order ROB slot allocator on the issue side. Hands out the tail index as
// the robIdx of each issued instruction, tracks occupancy, stalls issue when
// every slot is in flight, frees one slot per rob commit and re-synchronises
// with rob's head (index 0) on a pipeline clear.
//
// Ports
//   i_clk            clock
//   i_rst            synchronous reset, active-high, highest priority
//   i_clear          pipeline flush (same pulse that clears rob)
//   i_alloc_req      issue stage wants one slot this cycle
//   o_alloc_grant    slot granted; allocation fires on req && grant
//   o_alloc_idx      robIdx for the requesting instruction (= tail)
//   i_commit         rob retired its head entry this cycle
//   o_full           count == ROB_SLOTS
//   o_empty          count == 0
//   o_free_slots     ROB_SLOTS - count
//   o_err            sticky: commit seen while empty, cleared only by reset
//   o_stall_cycles   (ROB_ALLOC_STATS_EN) cycles with req && !grant
//   o_alloc_count    (ROB_ALLOC_STATS_EN) number of fires
//
// Optional feature macro: ROB_ALLOC_STATS_EN adds the two statistics counters.
// -----------------------------------------------------------------------------
module rob_alloc
    import rob_alloc_pkg::*;
#(
    parameter int ROB_SLOTS    = DEF_ROB_SLOTS,
    parameter int ROB_IDX_BITS = DEF_ROB_IDX_BITS,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_alloc_req,
    output logic                    o_alloc_grant,
    output logic [ROB_IDX_BITS-1:0] o_alloc_idx,
    input  logic                    i_commit,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [ROB_IDX_BITS:0]   o_free_slots,
`ifdef ROB_ALLOC_STATS_EN
    output logic [31:0]             o_stall_cycles,
    output logic [31:0]             o_alloc_count,
`endif
    output logic                    o_err
);

    localparam int CNT_W = ROB_IDX_BITS + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(ROB_SLOTS);
    localparam logic [FC_W-1:0]  FLUSH_C = FC_W'(FLUSH_CYCLES);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                  r_state;
    logic [FC_W-1:0]         r_flush_cnt;
    logic [ROB_IDX_BITS-1:0] r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_full;
    logic                    r_empty;
    logic [CNT_W-1:0]        r_free;
    logic                    r_err;

    state_t                  w_state_next;
    logic [FC_W-1:0]         w_flush_next;
    logic [ROB_IDX_BITS-1:0] w_tail_inc;
    logic [ROB_IDX_BITS-1:0] w_tail_next;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_err_next;
    logic                    w_grant;
    logic                    w_fire;
    logic                    w_dec;

    rob_ptr_wrap #(
        .SLOTS    (ROB_SLOTS),
        .IDX_BITS (ROB_IDX_BITS)
    ) u_tail_wrap (
        .i_idx      (r_tail),
        .o_idx_next (w_tail_inc)
    );

    // Grant depends only on registered state plus clear, never on the request, and
    // uses the registered full flag so a same-cycle commit cannot bypass a full ROB.
    assign w_grant = (r_state == ST_RUN) && !r_full && !i_clear;
    assign w_fire  = i_alloc_req && w_grant;

    // Next-state for tail, occupancy, sticky error and the flush FSM.
    always_comb begin
        w_state_next = r_state;
        w_flush_next = r_flush_cnt;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        w_err_next   = r_err;
        w_dec        = i_commit && (r_count != {CNT_W{1'b0}});

        if (i_clear) begin
            // Alloc and commit in the clear cycle are discarded; err keeps its value.
            w_tail_next  = {ROB_IDX_BITS{1'b0}};
            w_count_next = {CNT_W{1'b0}};
            w_err_next   = r_err;
        end else begin
            w_tail_next  = w_fire ? w_tail_inc : r_tail;
            w_count_next = r_count + CNT_W'(w_fire) - CNT_W'(w_dec);
            w_err_next   = r_err | (i_commit && (r_count == {CNT_W{1'b0}}));
        end

        case (r_state)
            ST_RUN: begin
                if (i_clear) begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = FLUSH_C;
                end else begin
                    w_state_next = ST_RUN;
                    w_flush_next = r_flush_cnt;
                end
            end
            ST_FLUSH: begin
                if (i_clear) begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = FLUSH_C;
                end else if (r_flush_cnt == FC_ONE) begin
                    w_state_next = ST_RUN;
                    w_flush_next = r_flush_cnt;
                end else begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = r_flush_cnt - FC_ONE;
                end
            end
            default: begin
                w_state_next = ST_FLUSH;
                w_flush_next = FLUSH_C;
            end
        endcase
    end

    // Tail, count, FSM and status flags; flags are decoded from the next count so
    // they are registered and line up with r_count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_C;
            r_tail      <= {ROB_IDX_BITS{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_free      <= SLOTS_C;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_next;
            r_tail      <= w_tail_next;
            r_count     <= w_count_next;
            r_full      <= (w_count_next == SLOTS_C);
            r_empty     <= (w_count_next == {CNT_W{1'b0}});
            r_free      <= SLOTS_C - w_count_next;
            r_err       <= w_err_next;
        end
    end

`ifdef ROB_ALLOC_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_alloc_count;

    // Free-running statistics; only reset clears them, clear does not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= 32'd0;
            r_alloc_count  <= 32'd0;
        end else begin
            r_stall_cycles <= (i_alloc_req && !w_grant) ? (r_stall_cycles + 32'd1) : r_stall_cycles;
            r_alloc_count  <= w_fire ? (r_alloc_count + 32'd1) : r_alloc_count;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_alloc_count  = r_alloc_count;
`endif

    assign o_alloc_grant = w_grant;
    assign o_alloc_idx   = r_tail;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_free_slots  = r_free;
    assign o_err         = r_err;

endmodule

// File: tb/tb_rob_alloc.sv
// -----------------------------------------------------------------------------
// tb_rob_alloc
// Self-checking bench for rob_alloc (default 16 slots, FLUSH_CYCLES = 1).
// A behavioural occupancy model is compared against the DUT on every falling
// edge; directed sequences add literal expectations for the tested scenarios.
// -----------------------------------------------------------------------------
module tb_rob_alloc;

    localparam int SLOTS = 16;
    localparam int FLUSH = 1;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_clear = 1'b0;
    logic       i_alloc_req = 1'b0;
    logic       i_commit = 1'b0;
    logic       o_alloc_grant;
    logic [3:0] o_alloc_idx;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_free_slots;
    logic       o_err;
`ifdef ROB_ALLOC_STATS_EN
    logic [31:0] o_stall_cycles;
    logic [31:0] o_alloc_count;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    // Model: occupancy, tail, sticky error and remaining blocked cycles.
    bit m_valid = 1'b0;
    int m_tail  = 0;
    int m_count = 0;
    int m_err   = 0;
    int m_block = 0;

    always #5 clk = ~clk;

    rob_alloc dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_clear        (i_clear),
        .i_alloc_req    (i_alloc_req),
        .o_alloc_grant  (o_alloc_grant),
        .o_alloc_idx    (o_alloc_idx),
        .i_commit       (i_commit),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_free_slots   (o_free_slots),
`ifdef ROB_ALLOC_STATS_EN
        .o_stall_cycles (o_stall_cycles),
        .o_alloc_count  (o_alloc_count),
`endif
        .o_err          (o_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model advance at each rising edge.
    always @(posedge clk) begin : model
        int g;
        int f;
        int nc;
        if (i_rst) begin
            m_valid <= 1'b1;
            m_tail  <= 0;
            m_count <= 0;
            m_err   <= 0;
            m_block <= FLUSH;
        end else if (m_valid) begin
            if (i_clear) begin
                m_tail  <= 0;
                m_count <= 0;
                m_block <= FLUSH;
            end else begin
                g  = (m_block == 0 && m_count < SLOTS) ? 1 : 0;
                f  = (i_alloc_req && g == 1) ? 1 : 0;
                nc = m_count + f;
                if (i_commit) begin
                    if (m_count == 0) m_err <= 1;
                    else nc = nc - 1;
                end
                m_tail  <= (m_tail + f) % SLOTS;
                m_count <= nc;
                if (m_block > 0) m_block <= m_block - 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : compare
        int eg;
        if (m_valid && !i_rst) begin
            eg = (m_block == 0 && m_count != SLOTS && !i_clear) ? 1 : 0;
            chk("m_grant", int'(o_alloc_grant), eg);
            if (eg == 1) chk("m_idx", int'(o_alloc_idx), m_tail);
            chk("m_full",  int'(o_full),  (m_count == SLOTS) ? 1 : 0);
            chk("m_empty", int'(o_empty), (m_count == 0) ? 1 : 0);
            chk("m_free",  int'(o_free_slots), SLOTS - m_count);
            chk("m_err",   int'(o_err), m_err);
        end
    end

    // Apply inputs for one cycle and stop at the falling edge for sampling.
    task automatic drive(input bit req, input bit cmt, input bit clr);
        i_alloc_req = req;
        i_commit    = cmt;
        i_clear     = clr;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        @(posedge clk); #1;
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_grant", int'(o_alloc_grant), 0);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_err",   int'(o_err), 0);
        adv();

        // Fill: 16 back-to-back fires
        for (int i = 0; i < SLOTS; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("fill_grant", int'(o_alloc_grant), 1);
            chk("fill_idx",   int'(o_alloc_idx), i);
            if (i == 0) chk("first_free", int'(o_free_slots), 16);
            adv();
        end
        drive(1'b1, 1'b0, 1'b0);
        chk("full_flag",  int'(o_full), 1);
        chk("full_grant", int'(o_alloc_grant), 0);
        adv();

        // Full plus commit: no bypass
        drive(1'b1, 1'b1, 1'b0);
        chk("fc_grant", int'(o_alloc_grant), 0);
        adv();
        drive(1'b1, 1'b0, 1'b0);
        chk("fc_grant_next", int'(o_alloc_grant), 1);
        chk("fc_idx_wrap",   int'(o_alloc_idx), 0);
        chk("fc_free",       int'(o_free_slots), 1);
        adv();
        drive(1'b0, 1'b0, 1'b0);
        chk("fc_full_again", int'(o_full), 1);
        adv();

        // Drain to count 3 (tail is 1)
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            adv();
        end

        // Steady state: fire and commit every cycle
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 1'b0);
            chk("ss_free", int'(o_free_slots), 13);
            chk("ss_idx",  int'(o_alloc_idx), (1 + k) % 16);
            adv();
        end

        // Build count=9, tail=9 from a clean clear
        drive(1'b0, 1'b0, 1'b1);
        adv();
        drive(1'b0, 1'b0, 1'b0);
        chk("clr_block", int'(o_alloc_grant), 0);
        adv();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            adv();
        end
        drive(1'b1, 1'b0, 1'b1);
        chk("flush_free_before", int'(o_free_slots), 7);
        chk("flush_grant", int'(o_alloc_grant), 0);
        adv();
        drive(1'b1, 1'b0, 1'b0);
        chk("flush_empty", int'(o_empty), 1);
        chk("flush_hold",  int'(o_alloc_grant), 0);
        adv();
        drive(1'b1, 1'b0, 1'b0);
        chk("flush_resume", int'(o_alloc_grant), 1);
        chk("flush_idx",    int'(o_alloc_idx), 0);
        adv();

        // Underflow: count is 1, commit twice
        drive(1'b0, 1'b1, 1'b0);
        adv();
        drive(1'b0, 1'b1, 1'b0);
        chk("uf_err_before", int'(o_err), 0);
        adv();
        drive(1'b0, 1'b0, 1'b0);
        chk("uf_err",   int'(o_err), 1);
        chk("uf_empty", int'(o_empty), 1);
        adv();
        drive(1'b0, 1'b0, 1'b1);
        adv();
        drive(1'b0, 1'b0, 1'b0);
        chk("uf_err_clear", int'(o_err), 1);
        adv();
        i_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        adv();
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("uf_err_rst", int'(o_err), 0);
        chk("rst2_free",  int'(o_free_slots), 16);
        adv();
        drive(1'b0, 1'b0, 1'b0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
